// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and types for the load/store unit: memory
//               access type encodings, FSM state enum, request/response
//               structs and small address-check helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Memory access type encodings (req_typ)
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // Memory function encodings (req_fcn)
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        fcn;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        misaligned;
        logic        fault;
    } lsu_resp_t;

    // True when the byte offset violates the natural alignment of the type.
    // Unknown type codes are treated as word accesses.
    function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] off);
        case (typ)
            MT_B, MT_BU: is_misaligned = 1'b0;
            MT_H, MT_HU: is_misaligned = off[0];
            default:     is_misaligned = |off;
        endcase
    endfunction

    // Clears the low address bits that fall below the access size.
    function automatic logic [31:0] natural_align(input logic [2:0] typ, input logic [31:0] addr);
        case (typ)
            MT_B, MT_BU: natural_align = addr;
            MT_H, MT_HU: natural_align = {addr[31:1], 1'b0};
            default:     natural_align = {addr[31:2], 2'b00};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the LSU. Builds the store
//               byte mask and replicated store data, and extracts/extends
//               load data from the returned memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic        fcn_i,
    input  logic [2:0]  typ_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shifted;

    // Byte-lane enables: only stores touch lanes, selected by size and offset
    always_comb begin
        wmask_o = 4'b0000;
        if (fcn_i == M_XWR) begin
            case (typ_i)
                MT_B, MT_BU: wmask_o = 4'b0001 << offset_i;
                MT_H, MT_HU: wmask_o = offset_i[1] ? 4'b1100 : 4'b0011;
                default:     wmask_o = 4'b1111;
            endcase
        end
    end

    // Replicate the right-justified store data across every lane it could land in
    always_comb begin
        case (typ_i)
            MT_B, MT_BU: wdata_o = {4{wdata_i[7:0]}};
            MT_H, MT_HU: wdata_o = {2{wdata_i[15:0]}};
            default:     wdata_o = wdata_i;
        endcase
    end

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend
    always_comb begin
        w_shifted = rdata_i >> {offset_i, 3'b000};
        case (typ_i)
            MT_B:    rdata_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MT_BU:   rdata_o = {24'd0, w_shifted[7:0]};
            MT_H:    rdata_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MT_HU:   rdata_o = {16'd0, w_shifted[15:0]};
            default: rdata_o = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit between an in-order core
//               and a valid/ready memory port. Sequences IDLE->REQ->WAIT->DONE,
//               stalls the core until the access completes, and reports bus
//               timeouts as faults.
//               Build option LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses
//               complete immediately with exc_misaligned instead of being
//               truncated to natural alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // Core side
    input  logic        req_val_i,
    input  logic        req_fcn_i,
    input  logic [2:0]  req_typ_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        resp_val_o,
    output logic [31:0] resp_rdata_o,
    output logic        exc_misaligned_o,
    output logic        exc_fault_o,
    // Memory side
    output logic        mem_req_val_o,
    input  logic        mem_req_rdy_i,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_wen_o,
    output logic [3:0]  mem_req_wmask_o,
    output logic [31:0] mem_req_wdata_o,
    input  logic        mem_resp_val_i,
    input  logic [31:0] mem_resp_data_i
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e          state_q;
    lsu_req_t            req_q;
    lsu_req_t            req_d;
    lsu_resp_t           resp_q;
    logic                resp_val_q;
    logic                mem_req_val_q;
    logic [c_cnt_w-1:0]  cnt_q;

    logic                w_trap;
    logic                w_timeout;
    logic [31:0]         w_load_data;

    // Misalignment either traps (no bus traffic) or is silently truncated
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(req_typ_i, req_addr_i[1:0]);
    assign req_d  = '{fcn: req_fcn_i, typ: req_typ_i, addr: req_addr_i, wdata: req_wdata_i};
`else
    assign w_trap = 1'b0;
    assign req_d  = '{fcn: req_fcn_i, typ: req_typ_i,
                      addr: natural_align(req_typ_i, req_addr_i), wdata: req_wdata_i};
`endif

    // The counter value seen here is the number of REQ/WAIT cycles already
    // completed, so this flags the last permitted cycle.
    assign w_timeout = (cnt_q == c_cnt_w'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .fcn_i    (req_q.fcn),
        .typ_i    (req_q.typ),
        .offset_i (req_q.addr[1:0]),
        .wdata_i  (req_q.wdata),
        .rdata_i  (mem_resp_data_i),
        .wmask_o  (mem_req_wmask_o),
        .wdata_o  (mem_req_wdata_o),
        .rdata_o  (w_load_data)
    );

    // Access sequencer: owns the registered request, timeout counter and all
    // handshake/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            resp_q        <= '0;
            resp_val_q    <= 1'b0;
            mem_req_val_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_val_i) begin
                        req_q <= req_d;
                        cnt_q <= '0;
                        if (w_trap) begin
                            state_q    <= ST_DONE;
                            resp_val_q <= 1'b1;
                            resp_q     <= '{rdata: 32'd0, misaligned: 1'b1, fault: 1'b0};
                        end else begin
                            state_q       <= ST_REQ;
                            mem_req_val_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // A timeout withdraws the request even if rdy arrives now
                    if (w_timeout) begin
                        state_q       <= ST_DONE;
                        mem_req_val_q <= 1'b0;
                        resp_val_q    <= 1'b1;
                        resp_q        <= '{rdata: 32'd0, misaligned: 1'b0, fault: 1'b1};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (mem_req_rdy_i) begin
                            state_q       <= ST_WAIT;
                            mem_req_val_q <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response on the final cycle still counts as success
                    if (mem_resp_val_i) begin
                        state_q    <= ST_DONE;
                        resp_val_q <= 1'b1;
                        resp_q     <= '{rdata: (req_q.fcn == M_XWR) ? 32'd0 : w_load_data,
                                        misaligned: 1'b0, fault: 1'b0};
                    end else if (w_timeout) begin
                        state_q    <= ST_DONE;
                        resp_val_q <= 1'b1;
                        resp_q     <= '{rdata: 32'd0, misaligned: 1'b0, fault: 1'b1};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    resp_val_q <= 1'b0;
                    resp_q     <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The core is released only in DONE; reset drops the stall immediately
    assign stall_o          = req_val_i && (state_q != ST_DONE) && !rst;

    assign resp_val_o       = resp_val_q;
    assign resp_rdata_o     = resp_q.rdata;
    assign exc_fault_o      = resp_q.fault;
    assign exc_misaligned_o = resp_q.misaligned;

    assign mem_req_val_o    = mem_req_val_q;
    assign mem_req_addr_o   = {req_q.addr[31:2], 2'b00};
    assign mem_req_wen_o    = req_q.fcn;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu. Directed accesses push expected
//               responses and memory requests into queues; independent
//               monitors pop and compare when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;
    import lsu_pkg::*;

    localparam int c_to = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_val = 1'b0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall_o, resp_val_o, exc_misaligned_o, exc_fault_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_val_o, mem_req_wen_o;
    logic        mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o;
    logic [3:0]  mem_req_wmask_o;
    logic        mem_resp_val = 1'b0;
    logic [31:0] mem_resp_data = 32'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        bit          mis;
        bit          flt;
        int          issue;
        int          lat;
    } exp_resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wen;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } exp_mreq_t;

    exp_resp_t exp_q[$];
    exp_mreq_t mreq_q[$];

    lsu #(.TIMEOUT_CYCLES(c_to)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_val_i        (req_val),
        .req_fcn_i        (req_fcn),
        .req_typ_i        (req_typ),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .stall_o          (stall_o),
        .resp_val_o       (resp_val_o),
        .resp_rdata_o     (resp_rdata_o),
        .exc_misaligned_o (exc_misaligned_o),
        .exc_fault_o      (exc_fault_o),
        .mem_req_val_o    (mem_req_val_o),
        .mem_req_rdy_i    (mem_req_rdy),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wen_o    (mem_req_wen_o),
        .mem_req_wmask_o  (mem_req_wmask_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_resp_val_i   (mem_resp_val),
        .mem_resp_data_i  (mem_resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor
    exp_resp_t er;
    always @(negedge clk) begin
        if (!rst && resp_val_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got resp_val=1 rdata=0x%08h want no response (cycle %0d)",
                         resp_rdata_o, cyc);
            end else begin
                er = exp_q.pop_front();
                chk("resp_rdata", resp_rdata_o, er.rdata);
                chk("resp_misaligned", 32'(exc_misaligned_o), 32'(er.mis));
                chk("resp_fault", 32'(exc_fault_o), 32'(er.flt));
                chk("resp_latency", 32'(cyc - er.issue), 32'(er.lat));
            end
        end
    end

    // Memory request monitor: contents at handshake, stability while stalled
    exp_mreq_t em;
    bit        prev_stalled = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_mask;
    always @(negedge clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled && !resp_val_o) begin
                chk("mreq_val_held", 32'(mem_req_val_o), 32'd1);
                chk("mreq_addr_held", mem_req_addr_o, prev_addr);
                chk("mreq_wdata_held", mem_req_wdata_o, prev_wdata);
                chk("mreq_mask_held", 32'(mem_req_wmask_o), 32'(prev_mask));
            end
            if (mem_req_val_o && mem_req_rdy) begin
                if (mreq_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mreq_unexpected: got addr=0x%08h want no memory request (cycle %0d)",
                             mem_req_addr_o, cyc);
                end else begin
                    em = mreq_q.pop_front();
                    chk("mreq_addr", mem_req_addr_o, em.addr);
                    chk("mreq_wen", 32'(mem_req_wen_o), 32'(em.wen));
                    chk("mreq_wmask", 32'(mem_req_wmask_o), 32'(em.mask));
                    chk("mreq_wdata", mem_req_wdata_o, em.wdata);
                end
            end
            prev_stalled = mem_req_val_o && !mem_req_rdy;
            prev_addr    = mem_req_addr_o;
            prev_wdata   = mem_req_wdata_o;
            prev_mask    = mem_req_wmask_o;
        end
    end

    // One access from the core's point of view, with a simple memory model.
    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after DONE.
    task automatic access(input bit fcn, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy_lo, input bit respond,
                          input logic [31:0] mdata, input logic [31:0] exp_rdata,
                          input bit exp_mis, input bit exp_flt, input int exp_lat,
                          input bit exp_mem, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_mwdata);
        int  lo   = rdy_lo;
        int  n    = 0;
        bit  hs   = 1'b0;
        bit  done = 1'b0;
        req_val   = 1'b1;
        req_fcn   = fcn;
        req_typ   = typ;
        req_addr  = addr;
        req_wdata = wdata;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        exp_q.push_back('{exp_rdata, exp_mis, exp_flt, cyc, exp_lat});
        if (exp_mem) mreq_q.push_back('{exp_maddr, fcn, exp_mask, exp_mwdata});
        #1;
        chk("stall_idle", 32'(stall_o), 32'd1);
        while (!done) begin
            @(posedge clk);
            #1;
            n++;
            mem_resp_val = 1'b0;
            if (hs) begin
                mem_resp_val  = respond;
                mem_resp_data = mdata;
            end
            if (resp_val_o) begin
                done = 1'b1;
                chk("stall_done", 32'(stall_o), 32'd0);
                chk("mreq_val_done", 32'(mem_req_val_o), 32'd0);
            end else if (n > 40) begin
                total++;
                bad++;
                $display("FAIL access_timeout: got no resp_val after %0d cycles want resp_val", n);
                done = 1'b1;
            end else if (!stall_o) begin
                chk("stall_busy", 32'(stall_o), 32'd1);
            end
            if (mem_req_val_o) begin
                mem_req_rdy = (lo == 0);
                if (lo > 0) lo--;
            end else begin
                mem_req_rdy = 1'b0;
            end
            hs = mem_req_val_o && mem_req_rdy;
        end
        @(posedge clk);
        #1;
        req_val      = 1'b0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
    endtask

    // Reset asserted mid-access, followed by a stray late memory response
    task automatic reset_mid(input bit in_wait);
        req_val   = 1'b1;
        req_fcn   = M_XRD;
        req_typ   = MT_W;
        req_addr  = 32'h0000_0600;
        req_wdata = 32'd0;
        mem_req_rdy = in_wait;
        if (in_wait) mreq_q.push_back('{32'h0000_0600, 1'b0, 4'b0000, 32'd0});
        @(posedge clk); #1;
        if (!in_wait) chk("rst_pre_mreq_val", 32'(mem_req_val_o), 32'd1);
        @(posedge clk); #1;
        mem_req_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_mreq_val", 32'(mem_req_val_o), 32'd0);
        chk("rst_mid_resp_val", 32'(resp_val_o), 32'd0);
        chk("rst_mid_mreq_addr", mem_req_addr_o, 32'd0);
        req_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_resp_val  = 1'b1;
        mem_resp_data = 32'hBAD0_BAD0;
        repeat (2) @(posedge clk);
        #1;
        mem_resp_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, with req_val high to show stall is suppressed
        req_val = 1'b1;
        #13;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_resp_val", 32'(resp_val_o), 32'd0);
        chk("reset_mreq_val", 32'(mem_req_val_o), 32'd0);
        chk("reset_exc", {30'd0, exc_misaligned_o, exc_fault_o}, 32'd0);
        chk("reset_rdata", resp_rdata_o, 32'd0);
        chk("reset_mreq_addr", mem_req_addr_o, 32'd0);
        req_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // fcn typ addr wdata rdy_lo resp mdata | rdata mis flt lat | mem maddr mask mwdata
        access(M_XRD, MT_B,  32'h0000_0103, 32'd0,         0, 1, 32'h80FF_FF00,
               32'hFFFF_FF80, 0, 0, 3, 1, 32'h0000_0100, 4'b0000, 32'd0);
        access(M_XWR, MT_H,  32'h0000_0202, 32'h0000_BEEF, 0, 1, 32'h1234_5678,
               32'd0,         0, 0, 3, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
        access(M_XRD, MT_W,  32'h0000_0300, 32'd0,         4, 1, 32'hDEAD_BEEF,
               32'hDEAD_BEEF, 0, 0, 7, 1, 32'h0000_0300, 4'b0000, 32'd0);
        access(M_XRD, MT_BU, 32'h0000_0101, 32'd0,         0, 1, 32'h1234_A5C3,
               32'h0000_00A5, 0, 0, 3, 1, 32'h0000_0100, 4'b0000, 32'd0);
        access(M_XRD, MT_H,  32'h0000_0202, 32'd0,         0, 1, 32'h8001_7FFF,
               32'hFFFF_8001, 0, 0, 3, 1, 32'h0000_0200, 4'b0000, 32'd0);
        access(M_XRD, MT_HU, 32'h0000_0200, 32'd0,         0, 1, 32'h1234_F00D,
               32'h0000_F00D, 0, 0, 3, 1, 32'h0000_0200, 4'b0000, 32'd0);
        access(M_XWR, MT_B,  32'h0000_0301, 32'h1234_56AB, 0, 1, 32'hFFFF_FFFF,
               32'd0,         0, 0, 3, 1, 32'h0000_0300, 4'b0010, 32'hABAB_ABAB);
        access(M_XWR, MT_W,  32'h0000_0400, 32'hCAFE_F00D, 2, 1, 32'd0,
               32'd0,         0, 0, 5, 1, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D);
        // Bus timeout while waiting for the response, then while waiting for rdy
        access(M_XRD, MT_W,  32'h0000_0500, 32'd0,         0, 0, 32'h7777_7777,
               32'd0,         0, 1, c_to + 1, 1, 32'h0000_0500, 4'b0000, 32'd0);
        access(M_XWR, MT_W,  32'h0000_0504, 32'h0000_0001, 1000, 1, 32'd0,
               32'd0,         0, 1, c_to + 1, 0, 32'd0, 4'b0000, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        access(M_XRD, MT_W,  32'h0000_0101, 32'd0,         0, 1, 32'h1122_3344,
               32'd0,         1, 0, 1, 0, 32'd0, 4'b0000, 32'd0);
        access(M_XRD, MT_H,  32'h0000_0203, 32'd0,         0, 1, 32'h8000_1234,
               32'd0,         1, 0, 1, 0, 32'd0, 4'b0000, 32'd0);
`else
        access(M_XRD, MT_W,  32'h0000_0101, 32'd0,         0, 1, 32'h1122_3344,
               32'h1122_3344, 0, 0, 3, 1, 32'h0000_0100, 4'b0000, 32'd0);
        access(M_XRD, MT_H,  32'h0000_0203, 32'd0,         0, 1, 32'h8000_1234,
               32'hFFFF_8000, 0, 0, 3, 1, 32'h0000_0200, 4'b0000, 32'd0);
`endif
        // Aligned access after the misaligned pair still works normally
        access(M_XRD, MT_B,  32'h0000_0700, 32'd0,         0, 1, 32'h0000_007F,
               32'h0000_007F, 0, 0, 3, 1, 32'h0000_0700, 4'b0000, 32'd0);

        reset_mid(1'b1);
        reset_mid(1'b0);

        // Unit recovers after the mid-access resets
        access(M_XRD, MT_HU, 32'h0000_0802, 32'd0,         1, 1, 32'h9ABC_0000,
               32'h0000_9ABC, 0, 0, 4, 1, 32'h0000_0800, 4'b0000, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mreq_queue_empty", 32'(mreq_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 255, is the maximum cycles spent in REQ+WAIT before a bus fault is reported.
- REQ-002: clk  in  1  clock; all state updates on posedge clk.
- REQ-003: rst  in  1  reset, asynchronous, active-high.
- REQ-004: req_val  in  1  core presents a memory instruction this cycle.
- REQ-005: req_fcn  in  1  0 = load, 1 = store.
- REQ-006: req_typ  in  3  MT_B, MT_H, MT_W, MT_BU, MT_HU (package encodings).
- REQ-007: req_addr  in  32  byte address (ALU result).
- REQ-008: req_wdata  in  32  store data (rs2), right-justified.
- REQ-009: stall  out  1  core must hold PC and request stable.
- REQ-010: resp_val  out  1  access complete; rdata/flags valid this cycle.
- REQ-011: resp_rdata  out  32  aligned, extended load data; 0 for stores and faults.
- REQ-012: exc_misaligned  out  1  misaligned-access exception, qualified by resp_val.
- REQ-013: exc_fault  out  1  bus timeout exception, qualified by resp_val.
- REQ-014: mem_req_val / mem_req_rdy  out/in  1/1  memory request handshake.
- REQ-015: mem_req_addr  out  32  word address, bits [1:0] = 0.
- REQ-016: mem_req_wen  out  1  store; mem_req_wmask  out  4  byte-lane enables.
- REQ-017: mem_req_wdata  out  32  store data replicated into the addressed lanes.
- REQ-018: mem_resp_val  in  1 / mem_resp_data  in  32  response (loads: data; stores: ack).

Function
- REQ-019: FSM states IDLE, REQ, WAIT, DONE; IDLE->REQ on accepted req_val, REQ->WAIT on mem_req_val&&mem_req_rdy, WAIT->DONE on mem_resp_val, DONE->IDLE unconditionally.
- REQ-020: The request is sampled in IDLE; addr/typ/fcn/wdata are registered and held through DONE.
- REQ-021: mem_req_val is high only in REQ; mem_req_addr/wen/wmask/wdata are stable while mem_req_val is high.
- REQ-022: stall = req_val && state != DONE; resp_val is high exactly one cycle, in DONE.
- REQ-023: If mem_req_rdy and mem_resp_val both arrive the cycle after REQ entry, minimum load/store latency is 3 cycles after req_val (REQ, WAIT, DONE).
- REQ-024: wmask: B -> 1 lane at addr[1:0]; H -> 2 lanes at addr[1]; W -> 4'b1111; loads -> 4'b0000.
- REQ-025: Load data is shifted right by 8*addr[1:0]; B/H sign-extend from bit 7/15, BU/HU zero-extend, W passes through.
- REQ-026: A cycle counter clears on IDLE->REQ, increments in REQ and WAIT; reaching TIMEOUT_CYCLES forces DONE with exc_fault=1, resp_rdata=0, and mem_req_val dropped.
- REQ-027: A mem_resp_val arriving in IDLE, REQ or DONE is ignored.
- REQ-028: In DONE the core advances; a req_val in the following IDLE cycle starts a new access with no extra bubble.

Reset
- REQ-029: rst forces IDLE immediately, including mid-transaction; stall, resp_val, mem_req_val, exc_* = 0, counter = 0, registered request = 0.
- REQ-030: An access aborted by reset produces no resp_val after reset release.

Configuration
- REQ-031: With LSU_MISALIGN_TRAP_EN defined, a misaligned H/HU (addr[0]) or W (addr[1:0]!=0) request goes IDLE->DONE with no memory request, exc_misaligned=1, resp_rdata=0.
- REQ-032: Without LSU_MISALIGN_TRAP_EN, the low address bits are truncated to natural alignment, the access proceeds normally, and exc_misaligned is tied 0.

Structure
- REQ-033: MT_* encodings, state enum, and the lsu_req/lsu_resp struct typedefs belong in the shared consts package.
- REQ-034: A combinational sub-module lsu_align holds wmask/wdata replication and load extraction/extension.

Verification
- REQ-035: LB addr 0x103, mem_resp_data 0x80FF_FF00 -> resp_rdata 0xFFFF_FF80, mem_req_addr 0x100, latency 3 cycles.
- REQ-036: SH addr 0x202 wdata 0x0000_BEEF -> wmask 4'b1100, mem_req_wdata 0xBEEF_BEEF, wen=1, resp_rdata 0.
- REQ-037: LW with mem_req_rdy held low 4 cycles -> mem_req_val/addr stable, stall high throughout, resp_val 1 cycle later than baseline +4.
- REQ-038: TIMEOUT_CYCLES=8, no mem_resp_val -> resp_val with exc_fault=1 after 8 REQ+WAIT cycles.
- REQ-039: LW addr 0x101 -> with macro exc_misaligned=1 and no mem_req_val; without macro mem_req_addr 0x100, exc_misaligned=0.
- REQ-040: rst asserted in WAIT -> mem_req_val/stall low same cycle; late mem_resp_val after release produces no resp_val.
